// File: rtl/game_pkg.sv
// Shared types and screen geometry for the player movement path.
// Provides dir_t, FSM states, screen limits and button priority encoding.
package game_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CHECK,
        ST_COMMIT,
        ST_BLOCK
    } state_t;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int SPRITE        = 4;
    localparam int WORDS_PER_ROW = 5;
    localparam int MAX_X         = SCREEN_W - SPRITE;
    localparam int MAX_Y         = SCREEN_H - SPRITE;

    // up > down > left > right
    function automatic dir_t btnDir(
        input logic up,
        input logic down,
        input logic left,
        input logic right
    );
        if (up)         return DIR_UP;
        else if (down)  return DIR_DOWN;
        else if (left)  return DIR_LEFT;
        else if (right) return DIR_RIGHT;
        else            return DIR_IDLE;
    endfunction

endpackage

// File: rtl/edge_addr_calc.sv
// Leading-edge pixel k of a 4x4 sprite at (cx,cy) moving in dir.
// Ports: cx,cy,dir,k in; pixel x,y, ROM word mapAddr and bitIdx out.
module edge_addr_calc import game_pkg::*; (
    input  logic [7:0] cx,
    input  logic [6:0] cy,
    input  dir_t       dir,
    input  logic [1:0] k,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [9:0] mapAddr,
    output logic [4:0] bitIdx
);

    always_comb begin
        x = cx;
        y = cy;
        unique case (dir)
            DIR_UP: begin
                x = cx + {6'd0, k};
            end
            DIR_DOWN: begin
                x = cx + {6'd0, k};
                y = cy + 7'd3;
            end
            DIR_LEFT: begin
                y = cy + {5'd0, k};
            end
            DIR_RIGHT: begin
                x = cx + 8'd3;
                y = cy + {5'd0, k};
            end
            default: ;
        endcase
    end

    // y*5 as (y<<2)+y, plus the 32-pixel column word
    assign mapAddr = ({3'd0, y} << 2) + {3'd0, y}
                   + {7'd0, x[7:5]};
    assign bitIdx  = x[4:0];

endmodule

// File: rtl/player_mover.sv
// Validates button moves against wall/coin bit-plane ROMs, drives animation.
// Ports: clock,resetn,tick,btn*,won,timesUp in; mapAddr out; wallQ,coinQ in;
// nextX,nextY,dir,ldXY,coinErase_en out. Option: PLAYER_WRAP_EN wraps edges.
module player_mover import game_pkg::*; #(
    parameter int START_X = 2,
    parameter int START_Y = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        tick,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        won,
    input  logic        timesUp,
    output logic [9:0]  mapAddr,
    input  logic [31:0] wallQ,
    input  logic [31:0] coinQ,
    output logic [7:0]  nextX,
    output logic [6:0]  nextY,
    output logic [2:0]  dir,
    output logic        ldXY,
    output logic        coinErase_en
);

    state_t     state;
    dir_t       dirR;
    dir_t       reqDir;
    logic [7:0] candX;
    logic [6:0] candY;
    logic [7:0] candXc;
    logic [6:0] candYc;
    logic       offEdge;
    logic [1:0] k;
    logic       coinFlag;
    logic [7:0] pixX;
    logic [6:0] pixY;
    logic [9:0] pixAddr;
    logic [4:0] bitIdx;
    logic       unusedPix;

    assign dir = dirR;

    always_comb begin
        reqDir  = btnDir(btnUp, btnDown, btnLeft, btnRight);
        candXc  = nextX;
        candYc  = nextY;
        offEdge = 1'b0;
        unique case (reqDir)
            DIR_UP: begin
                if (nextY == 7'd0) begin
`ifdef PLAYER_WRAP_EN
                    candYc = 7'(MAX_Y);
`else
                    offEdge = 1'b1;
`endif
                end else begin
                    candYc = nextY - 7'd1;
                end
            end
            DIR_DOWN: begin
                if (nextY == 7'(MAX_Y)) begin
`ifdef PLAYER_WRAP_EN
                    candYc = 7'd0;
`else
                    offEdge = 1'b1;
`endif
                end else begin
                    candYc = nextY + 7'd1;
                end
            end
            DIR_LEFT: begin
                if (nextX == 8'd0) begin
`ifdef PLAYER_WRAP_EN
                    candXc = 8'(MAX_X);
`else
                    offEdge = 1'b1;
`endif
                end else begin
                    candXc = nextX - 8'd1;
                end
            end
            DIR_RIGHT: begin
                if (nextX == 8'(MAX_X)) begin
`ifdef PLAYER_WRAP_EN
                    candXc = 8'd0;
`else
                    offEdge = 1'b1;
`endif
                end else begin
                    candXc = nextX + 8'd1;
                end
            end
            default: ;
        endcase
    end

    edge_addr_calc uEdge (
        .cx      (candX),
        .cy      (candY),
        .dir     (dirR),
        .k       (k),
        .x       (pixX),
        .y       (pixY),
        .mapAddr (pixAddr),
        .bitIdx  (bitIdx)
    );

    assign unusedPix = ^{pixX, pixY};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_INIT;
            dirR         <= DIR_IDLE;
            nextX        <= 8'(START_X);
            nextY        <= 7'(START_Y);
            candX        <= 8'(START_X);
            candY        <= 7'(START_Y);
            k            <= 2'd0;
            coinFlag     <= 1'b0;
            mapAddr      <= 10'd0;
            ldXY         <= 1'b0;
            coinErase_en <= 1'b0;
        end else begin
            ldXY         <= 1'b0;
            coinErase_en <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    ldXY  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (tick && reqDir != DIR_IDLE
                        && !won && !timesUp) begin
                        dirR  <= reqDir;
                        candX <= candXc;
                        candY <= candYc;
                        k     <= 2'd0;
                        state <= offEdge ? ST_BLOCK : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    mapAddr <= pixAddr;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    // k and the candidate are unchanged since ADDR,
                    // so bitIdx still points at the pixel just read
                    if (wallQ[bitIdx]) begin
                        state <= ST_BLOCK;
                    end else begin
                        if (coinQ[bitIdx]) coinFlag <= 1'b1;
                        if (k == 2'd3) begin
                            state <= ST_COMMIT;
                        end else begin
                            k     <= k + 2'd1;
                            state <= ST_ADDR;
                        end
                    end
                end
                ST_COMMIT: begin
                    nextX        <= candX;
                    nextY        <= candY;
                    ldXY         <= 1'b1;
                    coinErase_en <= coinFlag;
                    coinFlag     <= 1'b0;
                    state        <= ST_IDLE;
                end
                ST_BLOCK: begin
                    coinFlag <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
